// File: rtl/tri_wave_table_writer_if.sv
// ---------------------------------------------------------------------------
// tri_wave_table_writer_if
// Bundles the control handshake and both wave-RAM ports of the triangular
// wave-table writer.
//
//   start    : control  -> writer   one-cycle build/verify request
//   busy     : writer   -> control  sequence in progress
//   done     : writer   -> control  one-cycle end-of-sequence pulse
//   pass     : writer   -> control  1 = read-back found no mismatches
//   err_cnt  : writer   -> control  saturating mismatch count
//   wr_en/wr_addr/wr_data : writer -> RAM write port
//   rd_en/rd_addr         : writer -> RAM read port
//   rd_data               : RAM    -> writer read data
//
// Modports: master = the writer, slave = control logic + RAM side.
// ---------------------------------------------------------------------------
interface tri_wave_table_writer_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);

  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [7:0]            err_cnt;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    input  start,
    input  rd_data,
    output busy,
    output done,
    output pass,
    output err_cnt,
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_en,
    output rd_addr
  );

  modport slave (
    output start,
    output rd_data,
    input  busy,
    input  done,
    input  pass,
    input  err_cnt,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_en,
    input  rd_addr
  );

endinterface

// File: rtl/tri_wave_table_writer.sv
// ---------------------------------------------------------------------------
// tri_wave_table_writer
// Fills a dual-port wave RAM with a 2^ADDR_WIDTH-point triangular waveform,
// then reads the whole table back and checks every word. Lets the DAC wave
// table be rebuilt at run time without an init file.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : tri_wave_table_writer_if.master
//            start in / busy, done, pass, err_cnt out
//            wr_en, wr_addr, wr_data, rd_en, rd_addr out / rd_data in
//
// Parameters:
//   ADDR_WIDTH : table address width (9..16), depth N = 2^ADDR_WIDTH
//   DATA_WIDTH : sample width, <= ADDR_WIDTH-1
//   RD_LATENCY : RAM read latency, 1 (no output reg) or 2 (output reg)
// ---------------------------------------------------------------------------
module tri_wave_table_writer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  tri_wave_table_writer_if.master  bus
);

  if (ADDR_WIDTH < 9 || ADDR_WIDTH > 16 || DATA_WIDTH > ADDR_WIDTH - 1 ||
      DATA_WIDTH < 1 || RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_param_err
    $error("tri_wave_table_writer: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_VERIFY,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
  localparam logic [ADDR_WIDTH-1:0] DRAIN_LAST = ADDR_WIDTH'(RD_LATENCY - 1);

  // Rising half for the lower half of the table, mirrored for the upper half.
  function automatic logic [DATA_WIDTH-1:0] wave_sample(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] r;
    r = a[ADDR_WIDTH-2 -: DATA_WIDTH];
    return a[ADDR_WIDTH-1] ? ~r : r;
  endfunction

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [7:0]            r_err_cnt;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_rd_addr;

  logic                  r_pipe_vld [RD_LATENCY];
  logic [DATA_WIDTH-1:0] r_pipe_exp [RD_LATENCY];

  logic [ADDR_WIDTH-1:0] w_cnt_inc;
  logic                  w_cmp_vld;
  logic                  w_mismatch;
  logic [7:0]            w_err_next;

  always_comb begin
    w_cnt_inc  = r_cnt + ADDR_WIDTH'(1);
    w_cmp_vld  = r_pipe_vld[RD_LATENCY-1];
    w_mismatch = w_cmp_vld && (bus.rd_data != r_pipe_exp[RD_LATENCY-1]);
    w_err_next = r_err_cnt;
    if (w_mismatch && (r_err_cnt != 8'hFF)) begin
      w_err_next = r_err_cnt + 8'd1;
    end
  end

  // Stage 0 is loaded from the registered read port, so the last stage lines
  // up with rd_data exactly RD_LATENCY cycles after the RAM sees rd_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < unsigned'(RD_LATENCY); i++) begin
        r_pipe_vld[i] <= 1'b0;
        r_pipe_exp[i] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= r_rd_en;
      r_pipe_exp[0] <= wave_sample(r_rd_addr);
      for (int unsigned i = 1; i < unsigned'(RD_LATENCY); i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_exp[i] <= r_pipe_exp[i-1];
      end
    end
  end

  // r_cnt holds the address currently presented on the active RAM port, so
  // the first write is already registered on the edge that accepts start.
  // In DRAIN it counts the cycles still needed for the last compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err_cnt <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_done    <= 1'b0;
      r_err_cnt <= w_err_next;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state   <= S_WRITE;
            r_busy    <= 1'b1;
            r_pass    <= 1'b0;
            r_err_cnt <= '0;
            r_cnt     <= '0;
            r_wr_en   <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= wave_sample('0);
          end
        end
        S_WRITE: begin
          if (r_cnt == LAST_ADDR) begin
            r_state   <= S_VERIFY;
            r_cnt     <= '0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
          end else begin
            r_cnt     <= w_cnt_inc;
            r_wr_addr <= w_cnt_inc;
            r_wr_data <= wave_sample(w_cnt_inc);
          end
        end
        S_VERIFY: begin
          if (r_cnt == LAST_ADDR) begin
            r_state <= S_DRAIN;
            r_cnt   <= '0;
            r_rd_en <= 1'b0;
          end else begin
            r_cnt     <= w_cnt_inc;
            r_rd_addr <= w_cnt_inc;
          end
        end
        S_DRAIN: begin
          // The final compare lands on this same edge, so pass looks at the
          // updated count rather than the registered one.
          if (r_cnt == DRAIN_LAST) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 8'd0);
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_DONE: begin
          // One extra state keeps a start coincident with done from being
          // taken; busy drops as done drops.
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.pass    = r_pass;
  assign bus.err_cnt = r_err_cnt;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign bus.rd_en   = r_rd_en;
  assign bus.rd_addr = r_rd_addr;

endmodule

// File: tb/tb_tri_wave_table_writer.sv
// ---------------------------------------------------------------------------
// tb_tri_wave_table_writer
// Drives two writers side by side (RAM read latency 1 and 2) against
// behavioural wave RAMs. Expected end-of-run results are queued when a start
// is issued and compared when done pulses; writes and reads are checked
// against an independent triangle model as they appear.
// ---------------------------------------------------------------------------
module tb_tri_wave_table_writer;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int N  = 1 << AW;

  typedef struct {
    int idx;
    bit pass;
    int err;
  } res_t;

  logic clk;
  logic rst_n;
  logic start;
  int   cyc;
  int   s_cyc;
  int   mode;
  int   n_cmp;
  int   n_bad;
  int   wcnt  [2];
  int   rcnt  [2];
  int   ndone [2];
  res_t rq1 [$];
  res_t rq2 [$];

  tri_wave_table_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif1 ();
  tri_wave_table_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif2 ();

  tri_wave_table_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif1.master)
  );

  tri_wave_table_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign bif1.start = start;
  assign bif2.start = start;

  // Independent triangle: distance from the nearer table end, scaled down.
  function automatic logic [DW-1:0] model_f(input int a);
    int t;
    t = (a < N/2) ? a : (N - 1 - a);
    return DW'(t >> (AW - 1 - DW));
  endfunction

  function automatic logic [DW-1:0] ram_out(input int a, input logic [DW-1:0] v);
    case (mode)
      1:       return (a == 100 || a == 900) ? (v ^ 8'h5A) : v;
      2:       return '0;
      default: return v;
    endcase
  endfunction

  function automatic int exp_err();
    int c;
    c = 0;
    for (int a = 0; a < N; a++) begin
      if (ram_out(a, model_f(a)) != model_f(a)) c++;
    end
    return (c > 255) ? 255 : c;
  endfunction

  // RAM 1: registered read, latency 1. RAM 2: extra output register.
  logic [DW-1:0] mem1 [N];
  logic [DW-1:0] mem2 [N];
  logic [DW-1:0] q1, q2a, q2b;

  always @(posedge clk) begin
    if (bif1.wr_en) mem1[bif1.wr_addr] <= bif1.wr_data;
    if (bif1.rd_en) q1 <= ram_out(int'(bif1.rd_addr), mem1[bif1.rd_addr]);
    if (bif2.wr_en) mem2[bif2.wr_addr] <= bif2.wr_data;
    if (bif2.rd_en) q2a <= ram_out(int'(bif2.rd_addr), mem2[bif2.rd_addr]);
    q2b <= q2a;
  end

  assign bif1.rd_data = q1;
  assign bif2.rd_data = q2b;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic mon(input int d, input logic wr_en, input logic [AW-1:0] wa,
                     input logic [DW-1:0] wd, input logic rd_en, input logic [AW-1:0] ra,
                     input logic done, input logic pass, input logic [7:0] err);
    res_t e;
    bit   have;
    if (wr_en) begin
      check("wr_rd_excl", 32'(rd_en), 32'd0);
      check("wr_addr", 32'(wa), wcnt[d]);
      check("wr_data", 32'(wd), 32'(model_f(wcnt[d])));
      wcnt[d]++;
    end
    if (rd_en) begin
      check("rd_addr", 32'(ra), rcnt[d]);
      rcnt[d]++;
    end
    if (done) begin
      ndone[d]++;
      have = 1'b0;
      if (d == 0 && rq1.size() > 0) begin e = rq1.pop_front(); have = 1'b1; end
      if (d == 1 && rq2.size() > 0) begin e = rq2.pop_front(); have = 1'b1; end
      check("done_expected", 32'(have), 32'd1);
      if (have) begin
        check("done_cycle", cyc - s_cyc + 1, e.idx);
        check("pass", 32'(pass), 32'(e.pass));
        check("err_cnt", 32'(err), e.err);
        check("write_count", wcnt[d], N);
        check("read_count", rcnt[d], N);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, bif1.wr_en, bif1.wr_addr, bif1.wr_data, bif1.rd_en, bif1.rd_addr,
        bif1.done, bif1.pass, bif1.err_cnt);
    mon(1, bif2.wr_en, bif2.wr_addr, bif2.wr_data, bif2.rd_en, bif2.rd_addr,
        bif2.done, bif2.pass, bif2.err_cnt);
  end

  task automatic chk_rst_one(input string tag, input logic busy, input logic done,
                             input logic pass, input logic [7:0] err, input logic wr_en,
                             input logic rd_en, input logic [AW-1:0] wa,
                             input logic [AW-1:0] ra, input logic [DW-1:0] wd);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_wr_en"}, 32'(wr_en), 0);
    check({tag, "_rd_en"}, 32'(rd_en), 0);
    check({tag, "_wr_addr"}, 32'(wa), 0);
    check({tag, "_rd_addr"}, 32'(ra), 0);
    check({tag, "_wr_data"}, 32'(wd), 0);
  endtask

  task automatic chk_rst(input string tag);
    chk_rst_one({tag, "1"}, bif1.busy, bif1.done, bif1.pass, bif1.err_cnt, bif1.wr_en,
                bif1.rd_en, bif1.wr_addr, bif1.rd_addr, bif1.wr_data);
    chk_rst_one({tag, "2"}, bif2.busy, bif2.done, bif2.pass, bif2.err_cnt, bif2.wr_en,
                bif2.rd_en, bif2.wr_addr, bif2.rd_addr, bif2.wr_data);
  endtask

  // Start pulse sampled on the next rising edge; that edge becomes cycle 0.
  task automatic do_start();
    res_t e;
    int   ee;
    @(negedge clk);
    start = 1'b1;
    s_cyc = cyc + 1;
    ee    = exp_err();
    for (int d = 0; d < 2; d++) begin
      wcnt[d] = 0;
      rcnt[d] = 0;
    end
    e.pass = (ee == 0);
    e.err  = ee;
    e.idx  = 2*N + 2;
    rq1.push_back(e);
    e.idx  = 2*N + 3;
    rq2.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idx(input int k);
    for (int i = 0; i < 3*N && (cyc - s_cyc + 1) < k; i++) @(negedge clk);
  endtask

  task automatic pulse_at(input int k);
    wait_idx(k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3*N; i++) begin
      @(negedge clk);
      if (rq1.size() == 0 && rq2.size() == 0) break;
    end
    check("done_timeout", rq1.size() + rq2.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd0, nd1;
    n_cmp = 0;
    n_bad = 0;
    mode  = 0;
    cyc   = 0;
    s_cyc = 0;
    start = 1'b0;
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      wcnt[d] = 0; rcnt[d] = 0; ndone[d] = 0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_rst("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean table, both latencies.
    mode = 0;
    do_start();
    wait_done();
    repeat (5) @(negedge clk);
    check("pass_hold1", 32'(bif1.pass), 1);
    check("pass_hold2", 32'(bif2.pass), 1);
    check("busy_idle1", 32'(bif1.busy), 0);

    // Two corrupted words.
    mode = 1;
    do_start();
    wait_done();
    repeat (3) @(negedge clk);
    check("err_hold1", 32'(bif1.err_cnt), 2);

    // Every read returns zero: count must saturate.
    mode = 2;
    do_start();
    wait_done();
    repeat (3) @(negedge clk);
    check("err_sat_hold2", 32'(bif2.err_cnt), 255);

    // Stray starts while busy and coincident with done are ignored.
    mode = 1;
    nd0  = ndone[0];
    nd1  = ndone[1];
    do_start();
    pulse_at(5);
    pulse_at(1500);
    pulse_at(2*N + 2);
    wait_done();
    repeat (20) @(negedge clk);
    check("one_done1", ndone[0] - nd0, 1);
    check("one_done2", ndone[1] - nd1, 1);
    check("no_restart1", 32'(bif1.busy), 0);
    check("no_restart2", 32'(bif2.busy), 0);

    // Fresh start from IDLE clears the count.
    mode = 0;
    do_start();
    wait_done();

    // Asynchronous reset mid-write, then a full clean run.
    do_start();
    wait_idx(300);
    #2 rst_n = 1'b0;
    #1 chk_rst("async_rst");
    rq1.delete();
    rq2.delete();
    repeat (3) @(negedge clk);
    chk_rst("rst_hold");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_err1", 32'(bif1.err_cnt), 0);
    check("post_rst_busy2", 32'(bif2.busy), 0);
    do_start();
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
